// File: rtl/hex_display_scanner.sv
// Four-digit multiplexed seven-segment scanner with per-slot blanking and
// frame-synchronous double buffering of the displayed value.
module hex_display_scanner #(
  parameter int unsigned REFRESH_DIV = 16'd50000,
  parameter int unsigned BLANK_CYC   = 2,
  parameter int unsigned DIV_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam logic [DIV_WIDTH-1:0] CNT_LAST  = DIV_WIDTH'(REFRESH_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] BLANK_END = DIV_WIDTH'(BLANK_CYC);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [15:0]          pend_digits_q, pend_digits_d;
  logic [3:0]           pend_dp_q, pend_dp_d;
  logic [3:0]           pend_blank_q, pend_blank_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [15:0]          act_digits_q, act_digits_d;
  logic [3:0]           act_dp_q, act_dp_d;
  logic [3:0]           act_blank_q, act_blank_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 frame_done_q, frame_done_d;

  logic                 slot_wrap;
  logic                 frame_end;
  logic                 lit;
  logic [3:0]           cur_digit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      default: hex_to_seg = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    slot_wrap = (cnt_q == CNT_LAST);
    frame_end = slot_wrap && (idx_q == 2'd3);
    cnt_d     = slot_wrap ? '0 : cnt_q + DIV_WIDTH'(1);
    idx_d     = slot_wrap ? idx_q + 2'd1 : idx_q;

    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pend_valid_d  = pend_valid_q;
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    act_blank_d   = act_blank_q;

    if (load) begin
      pend_digits_d = digits_in;
      pend_dp_d     = dp_in;
      pend_blank_d  = blank_in;
      pend_valid_d  = 1'b1;
    end

    // A load landing on the boundary bypasses pending so it is not delayed a frame.
    if (frame_end) begin
      if (load) begin
        act_digits_d = digits_in;
        act_dp_d     = dp_in;
        act_blank_d  = blank_in;
      end else if (pend_valid_q) begin
        act_digits_d = pend_digits_q;
        act_dp_d     = pend_dp_q;
        act_blank_d  = pend_blank_q;
      end
      pend_valid_d = 1'b0;
    end

    cur_digit = act_digits_q[{idx_q, 2'b00} +: 4];
    lit       = (cnt_q >= BLANK_END) && !act_blank_q[idx_q];

    an_d = 4'b1111;
    if (lit) an_d[idx_q] = 1'b0;
    seg_d        = lit ? hex_to_seg(cur_digit) : 7'b1111111;
    dp_d         = lit ? ~act_dp_q[idx_q] : 1'b1;
    frame_done_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      pend_digits_q <= 16'h0000;
      pend_dp_q     <= 4'b0000;
      pend_blank_q  <= 4'b1111;
      pend_valid_q  <= 1'b0;
      act_digits_q  <= 16'h0000;
      act_dp_q      <= 4'b0000;
      act_blank_q   <= 4'b1111;
      an_q          <= 4'b1111;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_valid_q  <= pend_valid_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with REFRESH_DIV=8, BLANK_CYC=2:
// a time-indexed reference predicts {an, seg, dp, frame_done} every clock.
module tb_hex_display_scanner;

  localparam int W = 13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .REFRESH_DIV(8),
    .BLANK_CYC  (2),
    .DIV_WIDTH  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .blank_in  (blank_in),
    .load      (load),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  logic [W-1:0] exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] obs;

  // Reference state: m_t counts clocks since reset release.
  int          m_t;
  logic [15:0] m_act_dig, m_pend_dig;
  logic [3:0]  m_act_dp, m_act_bl, m_pend_dp, m_pend_bl;
  logic        m_pv;

  localparam logic [W-1:0] DARK = {4'b1111, 7'b1111111, 1'b1, 1'b0};

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: seg_ref = 7'b1000000;  4'h1: seg_ref = 7'b1111001;
      4'h2: seg_ref = 7'b0100100;  4'h3: seg_ref = 7'b0110000;
      4'h4: seg_ref = 7'b0011001;  4'h5: seg_ref = 7'b0010010;
      4'h6: seg_ref = 7'b0000010;  4'h7: seg_ref = 7'b1111000;
      4'h8: seg_ref = 7'b0000000;  4'h9: seg_ref = 7'b0010000;
      4'hA: seg_ref = 7'b0001000;  4'hB: seg_ref = 7'b0000011;
      4'hC: seg_ref = 7'b1000110;  4'hD: seg_ref = 7'b0100001;
      4'hE: seg_ref = 7'b0000110;  default: seg_ref = 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s t=%0d: observed {an,seg,dp,fd}=%b expected=%b", tag, m_t, o, e);
    end
  endtask

  task automatic model_reset();
    m_t        = 0;
    m_act_dig  = 16'h0000;  m_act_dp  = 4'b0000;  m_act_bl  = 4'b1111;
    m_pend_dig = 16'h0000;  m_pend_dp = 4'b0000;  m_pend_bl = 4'b1111;
    m_pv       = 1'b0;
  endtask

  // Drive one clock of stimulus, predict the registered output, then compare.
  task automatic step(input string tag, input logic ld, input logic [15:0] d,
                      input logic [3:0] p, input logic [3:0] b);
    int           slot, pos;
    logic         lit, bnd;
    logic [3:0]   a;
    logic [W-1:0] e;
    load = ld; digits_in = d; dp_in = p; blank_in = b;
    slot = (m_t / 8) % 4;
    pos  = m_t % 8;
    bnd  = (m_t % 32 == 31);
    lit  = (pos >= 2) && !m_act_bl[slot];
    a    = 4'b1111;
    if (lit) a[slot] = 1'b0;
    e = {a, lit ? seg_ref(m_act_dig[slot*4 +: 4]) : 7'b1111111,
         lit ? ~m_act_dp[slot] : 1'b1, bnd};
    exp_q.push_back(e);
    if (ld) begin
      m_pend_dig = d; m_pend_dp = p; m_pend_bl = b; m_pv = 1'b1;
    end
    if (bnd) begin
      if (ld) begin
        m_act_dig = d; m_act_dp = p; m_act_bl = b;
      end else if (m_pv) begin
        m_act_dig = m_pend_dig; m_act_dp = m_pend_dp; m_act_bl = m_pend_bl;
      end
      m_pv = 1'b0;
    end
    m_t++;
    @(posedge clk);
    #1;
    obs = {an, seg, dp, frame_done};
    check(tag, obs, exp_q.pop_front());
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 16'h0000, 4'h0, 4'h0);
  endtask

  initial begin
    rst_n = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; blank_in = '0;
    model_reset();
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_hold", {an, seg, dp, frame_done}, DARK);
    end
    @(negedge clk) rst_n = 1'b1;

    idle("reset_idle", 64);

    step("scan_load", 1'b1, 16'h4321, 4'b0001, 4'b0000);
    idle("scan", 33);
    step("scan", 1'b0, 16'h0, 4'h0, 4'h0);
    check("scan_slot0_spot", obs, {4'b1110, 7'b1111001, 1'b0, 1'b0});

    idle("tear", 7);
    step("tear_load", 1'b1, 16'hABCD, 4'b0000, 4'b0000);
    idle("tear", 7);
    step("tear", 1'b0, 16'h0, 4'h0, 4'h0);
    check("tear_slot2_spot", obs, {4'b1011, 7'b0110000, 1'b1, 1'b0});
    idle("tear", 15);
    step("tear", 1'b0, 16'h0, 4'h0, 4'h0);
    check("tear_next_frame_spot", obs, {4'b1110, 7'b0100001, 1'b1, 1'b0});

    step("dbl_load1", 1'b1, 16'h1111, 4'b0000, 4'b0000);
    idle("dbl", 5);
    step("dbl_load2", 1'b1, 16'h2222, 4'b0000, 4'b0000);
    idle("dbl", 24);
    step("dbl", 1'b0, 16'h0, 4'h0, 4'h0);
    check("dbl_last_wins_spot", obs, {4'b1110, 7'b0100100, 1'b1, 1'b0});
    idle("dbl", 60);

    step("bnd_load", 1'b1, 16'h8888, 4'b0000, 4'b0000);
    check("bnd_frame_done_spot", obs, {4'b0111, 7'b0100100, 1'b1, 1'b1});
    idle("bnd", 2);
    step("bnd", 1'b0, 16'h0, 4'h0, 4'h0);
    check("bnd_slot0_spot", obs, {4'b1110, 7'b0000000, 1'b1, 1'b0});

    step("mask_load", 1'b1, 16'hF000, 4'b0000, 4'b1110);
    idle("mask", 30);
    step("mask", 1'b0, 16'h0, 4'h0, 4'h0);
    check("mask_slot0_spot", obs, {4'b1110, 7'b1000000, 1'b1, 1'b0});
    idle("mask", 7);
    step("mask", 1'b0, 16'h0, 4'h0, 4'h0);
    check("mask_slot1_dark_spot", obs, DARK);
    idle("mask", 24);

    step("midrst_load", 1'b1, 16'h5555, 4'b0000, 4'b0000);
    #2 rst_n = 1'b0;
    load = 1'b0;
    #1 check("midrst_immediate_dark", {an, seg, dp, frame_done}, DARK);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle("after_midrst", 66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
